// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver front end: synchronizes the raw PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop), and queues good
// bytes in a small FIFO popped through a ready / nextdata_n handshake.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       frame_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] csync_q, csync_d;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [9:0]             shreg_q, shreg_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   frame_err_q, frame_err_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [FIFO_DEPTH];

    logic fall;
    logic bit_in;
    logic frame_ok;
    logic push_req;
    logic full;
    logic not_empty;
    logic pop;
    logic push;

    // Edge detect on the two oldest clock stages; data taken from its oldest stage.
    assign fall   = csync_q[SYNC_STAGES-1] & ~csync_q[SYNC_STAGES-2];
    assign bit_in = dsync_q[SYNC_STAGES-1];

    // Shift the raw lines into the synchronizer chains.
    always_comb begin
        csync_d = {csync_q[SYNC_STAGES-2:0], ps2_clk};
        dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    end

    // Start bit low, stop bit (current sample) high, odd parity over data+parity.
    assign frame_ok = ~shreg_q[0] & bit_in & (^shreg_q[9:1]);

    // Deframer: bit capture, stop-bit evaluation and partial-frame timeout.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tcnt_d      = tcnt_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        if (fall) begin
            tcnt_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d    = 4'd0;
                push_req    = frame_ok;
                frame_err_d = ~frame_ok;
            end else begin
                shreg_d[bitcnt_q] = bit_in;
                bitcnt_d          = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tcnt_q == T_LAST) begin
                bitcnt_d = 4'd0;
                tcnt_d   = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end else begin
            tcnt_d = '0;
        end
    end

    assign full      = (cnt_q == FULL_CNT);
    assign not_empty = (cnt_q != '0);
    assign pop       = ~nextdata_n & not_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push      = push_req & (~full | pop);

    // FIFO pointers, occupancy and the sticky overflow flag (set wins over clear).
    always_comb begin
        wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    // Control and deframing state; synchronizers idle high.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            csync_q     <= '1;
            dsync_q     <= '1;
            bitcnt_q    <= 4'd0;
            shreg_q     <= '0;
            tcnt_q      <= '0;
            frame_err_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            csync_q     <= csync_d;
            dsync_q     <= dsync_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tcnt_q      <= tcnt_d;
            frame_err_q <= frame_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= shreg_q[8:1];
        end
    end

    assign data      = not_empty ? mem_q[rptr_q] : 8'h00;
    assign ready     = not_empty;
    assign overflow  = overflow_q;
    assign sampling  = fall;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven at a slow bit rate, a
// queue-based model of the receive FIFO checked every cycle, plus literal
// expectations for each scenario.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TOUT  = 64;
    localparam int HALF  = 6;

    logic       clk        = 1'b0;
    logic       clrn       = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0] mq[$];
    bit         m_ovf      = 1'b0;
    bit         m_ferr     = 1'b0;
    bit         samp_ev    = 1'b0;
    bit         frame_ev   = 1'b0;
    bit         frame_good = 1'b0;
    logic [7:0] frame_byte = 8'h00;
    int         samp_cnt   = 0;
    int         ferr_cnt   = 0;
    bit         checking   = 1'b0;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (3),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .sampling  (sampling),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue model: pops, pushes, drops and the bad-frame pulse, per clock.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            bit pop_now;
            bit was_full;
            pop_now  = !nextdata_n && (mq.size() != 0);
            was_full = (mq.size() == DEPTH);
            m_ferr   = frame_ev && !frame_good;
            if (pop_now) begin
                void'(mq.pop_front());
                m_ovf = 1'b0;
            end
            if (frame_ev && frame_good) begin
                if (!was_full || pop_now) mq.push_back(frame_byte);
                else m_ovf = 1'b1;
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (checking && clrn) begin
            if (sampling)  samp_cnt++;
            if (frame_err) ferr_cnt++;
            chk("sampling",  {31'd0, sampling},  {31'd0, samp_ev});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            chk("ready",     {31'd0, ready},     {31'd0, (mq.size() != 0)});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            if (mq.size() != 0) chk("data", {24'd0, data}, {24'd0, mq[0]});
        end
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip_par);
        logic par;
        par = (~^b) ^ flip_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    // One PS/2 bit: data set while clock high, then a falling edge. The DUT's
    // edge detector sees the fall two clocks later; that cycle is marked.
    task automatic send_bit(input logic b, input bit last, input bit good,
                            input logic [7:0] byt, input bit pop_at_end);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1;
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        samp_ev = 1'b1;
        if (last) begin
            frame_ev   = 1'b1;
            frame_good = good;
            frame_byte = byt;
            if (pop_at_end) nextdata_n = 1'b0;
        end
        @(posedge clk);
        #1;
        samp_ev  = 1'b0;
        frame_ev = 1'b0;
        if (pop_at_end) nextdata_n = 1'b1;
        repeat (HALF - 3) @(posedge clk);
        #1;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit pop_at_end);
        logic [10:0] f;
        f = mk_frame(b, flip_par);
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i], (i == 10), !flip_par, b, pop_at_end);
        end
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, {24'd0, data}, {24'd0, exp});
        nextdata_n = 1'b0;
        @(posedge clk);
        #1;
        nextdata_n = 1'b1;
    endtask

    initial begin
        logic [10:0] f;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",    {31'd0, ready},     32'd0);
        chk("rst_data",     {24'd0, data},      32'd0);
        chk("rst_overflow", {31'd0, overflow},  32'd0);
        chk("rst_sampling", {31'd0, sampling},  32'd0);
        chk("rst_ferr",     {31'd0, frame_err}, 32'd0);
        #2 clrn = 1'b1;
        checking = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1: single good frame 0x1C
        samp_cnt = 0;
        ferr_cnt = 0;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t1_samples", samp_cnt, 32'd11);
        chk("t1_ready",   {31'd0, ready}, 32'd1);
        chk("t1_data",    {24'd0, data},  32'h1C);
        chk("t1_ferr",    ferr_cnt, 32'd0);
        pop_chk("t1_pop", 8'h1C);
        chk("t1_empty", {31'd0, ready}, 32'd0);

        // 2: parity error, then a good 0xF0
        ferr_cnt = 0;
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t2_ferr_cnt", ferr_cnt, 32'd1);
        chk("t2_ready",    {31'd0, ready}, 32'd0);
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("t2_data", {24'd0, data}, 32'hF0);
        pop_chk("t2_pop", 8'hF0);

        // 3: nine frames without pops -> overflow, drain eight
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("t3_ready",    {31'd0, ready},    32'd1);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        pop_chk("t3_pop1", 8'h01);
        chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 2; i <= 8; i++) pop_chk("t3_pop", 8'(i));
        chk("t3_empty", {31'd0, ready}, 32'd0);

        // 4: full FIFO, pop coincides with the ninth frame's completion
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
        send_frame(8'h19, 1'b0, 1'b1);
        chk("t4_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) pop_chk("t4_drain", 8'h12 + 8'(i));
        chk("t4_empty", {31'd0, ready}, 32'd0);

        // 5: abandoned partial frame, then a good 0x2A
        ferr_cnt = 0;
        f = mk_frame(8'h33, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0, 1'b1, 8'h33, 1'b0);
        repeat (TOUT + 20) @(posedge clk);
        #1;
        send_frame(8'h2A, 1'b0, 1'b0);
        chk("t5_ferr_cnt", ferr_cnt, 32'd0);
        chk("t5_data",     {24'd0, data}, 32'h2A);
        pop_chk("t5_pop", 8'h2A);
        chk("t5_empty", {31'd0, ready}, 32'd0);

        // 6: async reset mid-frame with three bytes queued
        send_frame(8'h41, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0);
        send_frame(8'h43, 1'b0, 1'b0);
        chk("t6_queued", {31'd0, ready}, 32'd1);
        f = mk_frame(8'h77, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(f[i], 1'b0, 1'b1, 8'h77, 1'b0);
        @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        chk("t6_rst_ready",    {31'd0, ready},    32'd0);
        chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("t6_rst_data",     {24'd0, data},     32'd0);
        repeat (2) @(posedge clk);
        #4 clrn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("t6_data", {24'd0, data}, 32'h5A);
        pop_chk("t6_pop", 8'h5A);
        chk("t6_empty", {31'd0, ready}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Front-end PS/2 receiver for the keyboard path. It oversamples the raw ps2_clk/ps2_data lines on the system clock, deframes 11-bit PS/2 frames, and checks start, stop and odd parity. Good scan-code bytes are pushed into a small FIFO. Downstream logic (key-state FSM, ASCII conversion, key counter, 7-segment display) consumes bytes through a ready/nextdata_n pop handshake.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, ≥2.
SYNC_STAGES, 3, synchronizer flops on ps2_clk and ps2_data; ≥2.
TIMEOUT_CYCLES, 50000, system-clock cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock; all state on posedge.
clrn  input  1  reset, asynchronous assert, active-low; clears all state.
ps2_clk  input  1  raw PS/2 clock, asynchronous.
ps2_data  input  1  raw PS/2 data, asynchronous.
nextdata_n  input  1  active-low pop request; sampled each clk.
data  output  8  byte at FIFO head; valid only while ready=1.
ready  output  1  FIFO non-empty.
overflow  output  1  sticky flag: a good frame was dropped because the FIFO was full.
sampling  output  1  one-cycle pulse on each detected ps2_clk falling edge.
frame_err  output  1  one-cycle pulse when a completed frame fails start, stop or parity checks.

Behaviour:
- Reset is asynchronous and active-low on clrn. It clears the bit counter, shift register, timeout counter, FIFO pointers and occupancy, overflow, sampling and frame_err. Synchronizers reset to all-1 (idle bus level). After reset: data=0, ready=0.
- Synchronization: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is the condition where the last two ps2_clk stages are 1 then 0. sampling is asserted combinationally in that cycle.
- Deframing:
  - bitcnt runs 0..10.
  - On each falling edge, the synchronized ps2_data is stored into buf[bitcnt].
  - For bitcnt <10, bitcnt increments.
  - At bitcnt==10 (stop bit), the frame is evaluated in the same cycle and bitcnt returns to 0.
- Frame checks: the frame is good iff buf[0]==0, stop bit==1, and XOR of buf[9:1]==1 (odd parity). The byte is buf[8:1], LSB first.
  - Bad frame: frame_err pulses for 1 cycle, the byte is discarded, FIFO and overflow are unchanged.
- Timeout: tcnt counts cycles while bitcnt≠0 and resets to 0 on every falling edge.
  - On reaching TIMEOUT_CYCLES−1: bitcnt←0, tcnt←0, no push, no frame_err.
  - Idle (bitcnt==0) holds tcnt at 0.
- FIFO storage: a register array indexed by wptr/rptr, each log2(FIFO_DEPTH) bits, wrapping naturally. A separate occupancy counter cnt (0..FIFO_DEPTH) gives full = cnt==FIFO_DEPTH; ready = cnt≠0; data = mem[rptr].
- Push: on a good-frame cycle, write mem[wptr] and advance wptr at that clk edge. ready therefore rises the cycle after the stop-bit sampling pulse (latency 1 cycle from sampling).
- Pop: when nextdata_n==0 and ready==1, advance rptr at the clk edge; the next byte or ready=0 is visible the following cycle. nextdata_n==0 while empty is ignored.
- Overflow:
  - A good frame arriving while full, with no simultaneous pop, is dropped and overflow is set.
  - overflow clears on the next successful pop. If a drop and a clear happen in the same cycle, set has priority.
- Simultaneous push+pop:
  - Not full: both happen and cnt is unchanged.
  - Full: the pop frees the slot, the push succeeds, and overflow is not set.
- Reset mid-frame or mid-FIFO: everything is discarded. After clrn deasserts, the first falling edge is treated as a start bit.

Test Plan:
1. Send frame for 0x1C (start 0, bits 00111000 LSB first, parity 0, stop 1) -> sampling pulses 11×; ready=1 one cycle after the 11th pulse; data=0x1C; frame_err=0.
2. Send 0x1C with parity bit flipped to 1 -> frame_err pulses once; ready stays 0. A following good 0xF0 frame -> data=0xF0.
3. Send 9 frames 0x01..0x09 with no pops -> ready=1, overflow=1. Pop 8× -> data sequence 0x01..0x08; overflow clears after the first pop; ready=0 after the 8th.
4. FIFO full (8 entries); hold nextdata_n=0 in the exact cycle the 9th good frame completes -> overflow stays 0; cnt stays 8; after draining, the last byte read is the 9th byte.
5. Send 5 bits, then no ps2_clk edges for TIMEOUT_CYCLES cycles, then a full 0x2A frame -> no frame_err, data=0x2A.
6. Pulse clrn low asynchronously (between clk edges) after 6 bits with 3 bytes queued -> ready=0, overflow=0 immediately. A subsequent 0x5A frame -> data=0x5A.
